// File: rtl/sprite_blitter_pkg.sv
// Shared types and helpers for the sprite blitter and its address generator.
package sprite_blitter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] KEY_COLOUR_DEF = 4'hF;

  // Bits needed to hold values 0..n-1 (at least one bit).
  function automatic int unsigned bits_for(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Raster-order ROM address walker: column/row counters, sprite base address and last-pixel flag.
module sprite_addr_gen
  import sprite_blitter_pkg::*;
#(
  parameter int SPR_W       = 50,
  parameter int SPR_H       = 50,
  parameter int NUM_SPRITES = 3,
  parameter int ADDR_W      = 13,
  parameter int SEL_W       = 2,
  parameter int COL_W       = 6,
  parameter int ROW_W       = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [COL_W-1:0]  col_o,
  output logic [ROW_W-1:0]  row_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam int PIX = SPR_W * SPR_H;

  if (ADDR_W < bits_for(NUM_SPRITES * PIX)) begin : g_addr_too_narrow
    $error("ADDR_W too narrow for NUM_SPRITES*SPR_W*SPR_H");
  end

  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] base;

  // Out-of-range sprite indices fall back to sprite 0.
  always_comb begin
    base = '0;
    if (int'(sel_i) < NUM_SPRITES) base = ADDR_W'(int'(sel_i) * PIX);
  end

  // Sprites are packed contiguously, so raster order is a plain address increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else if (load_i) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= base;
    end else if (step_i) begin
      if (col_q == COL_W'(SPR_W - 1)) begin
        col_q <= '0;
        row_q <= row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
      addr_q <= addr_q + ADDR_W'(1);
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign addr_o = addr_q;
  assign last_o = (col_q == COL_W'(SPR_W - 1)) && (row_q == ROW_W'(SPR_H - 1));

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks one ROM sprite and emits clipped, colour-keyed pixel writes, one per cycle.
module sprite_blitter
  import sprite_blitter_pkg::*;
#(
  parameter int SPR_W       = 50,
  parameter int SPR_H       = 50,
  parameter int NUM_SPRITES = 3,
  parameter int X_W         = 9,
  parameter int Y_W         = 9,
  parameter int COLOUR_W    = 4,
  parameter int ADDR_W      = 13,
  parameter int SCREEN_W    = 320,
  parameter int SCREEN_H    = 240,
  parameter int ROM_LAT     = 1,
  parameter logic [COLOUR_W-1:0] KEY_COLOUR = COLOUR_W'(KEY_COLOUR_DEF)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [1:0]          sprite_sel,
  input  logic [X_W-1:0]      origin_x,
  input  logic [Y_W-1:0]      origin_y,
  input  logic                key_en,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic                writeEn,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour
);

  localparam int COL_W = bits_for(SPR_W);
  localparam int ROW_W = bits_for(SPR_H);
  localparam int CNT_W = bits_for(ROM_LAT + 1);
  localparam int XS_W  = X_W + 1;
  localparam int YS_W  = Y_W + 1;

  state_e           state_q;
  logic             busy_q, done_q, key_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [X_W-1:0]   ox_q;
  logic [Y_W-1:0]   oy_q;

  logic             load, step, last;
  logic             vld_p0;
  logic [COL_W-1:0] col_p0;
  logic [ROW_W-1:0] row_p0;

  logic             vld_p_q [ROM_LAT];
  logic [COL_W-1:0] col_p_q [ROM_LAT];
  logic [ROW_W-1:0] row_p_q [ROM_LAT];

  logic                we_d, we_q;
  logic [X_W-1:0]      x_d, x_q;
  logic [Y_W-1:0]      y_d, y_q;
  logic [COLOUR_W-1:0] colour_d, colour_q;
  logic [XS_W-1:0]     x_sum;
  logic [YS_W-1:0]     y_sum;

  // On-screen test on the widened sums; the carry bit marks coordinate overflow.
  function automatic logic pix_visible(input logic [XS_W-1:0] xs, input logic [YS_W-1:0] ys);
    return !xs[X_W] && !ys[Y_W] && (xs < XS_W'(SCREEN_W)) && (ys < YS_W'(SCREEN_H));
  endfunction

  assign load   = (state_q == ST_IDLE) && start;
  assign step   = (state_q == ST_DRAW) && !last;
  assign vld_p0 = (state_q == ST_DRAW);

  sprite_addr_gen #(
    .SPR_W       (SPR_W),
    .SPR_H       (SPR_H),
    .NUM_SPRITES (NUM_SPRITES),
    .ADDR_W      (ADDR_W),
    .SEL_W       (2),
    .COL_W       (COL_W),
    .ROW_W       (ROW_W)
  ) u_addr_gen (
    .clk_i  (clock),
    .rst_ni (resetn),
    .load_i (load),
    .step_i (step),
    .sel_i  (sprite_sel),
    .col_o  (col_p0),
    .row_o  (row_p0),
    .addr_o (rom_addr),
    .last_o (last)
  );

  // Control FSM with registered busy/done; request parameters are captured on acceptance.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      flush_cnt_q <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      key_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_DRAW;
            busy_q  <= 1'b1;
            ox_q    <= origin_x;
            oy_q    <= origin_y;
            key_q   <= key_en;
          end
        end
        ST_DRAW: begin
          if (last) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= '0;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_q == CNT_W'(ROM_LAT)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---- p0 -> p1..pN: valid bits track each outstanding ROM read ----
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ROM_LAT; i++) vld_p_q[i] <= 1'b0;
    end else begin
      vld_p_q[0] <= vld_p0;
      for (int i = 1; i < ROM_LAT; i++) vld_p_q[i] <= vld_p_q[i-1];
    end
  end

  // Sprite coordinates ride alongside the valid bits; only meaningful when valid.
  always_ff @(posedge clock) begin
    col_p_q[0] <= col_p0;
    row_p_q[0] <= row_p0;
    for (int i = 1; i < ROM_LAT; i++) begin
      col_p_q[i] <= col_p_q[i-1];
      row_p_q[i] <= row_p_q[i-1];
    end
  end

  // ---- pN -> output: screen position, clipping and colour key ----
  always_comb begin
    x_sum    = {1'b0, ox_q} + XS_W'(col_p_q[ROM_LAT-1]);
    y_sum    = {1'b0, oy_q} + YS_W'(row_p_q[ROM_LAT-1]);
    we_d     = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    if (vld_p_q[ROM_LAT-1]) begin
      x_d      = x_sum[X_W-1:0];
      y_d      = y_sum[Y_W-1:0];
      colour_d = rom_data;
      we_d     = pix_visible(x_sum, y_sum) && !(key_q && (rom_data == KEY_COLOUR));
    end
  end

  // Registered pixel outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      we_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      we_q     <= we_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign writeEn = we_q;
  assign x       = x_q;
  assign y       = y_q;
  assign colour  = colour_q;

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
Parametrised sprite-drawing engine for the VGA adapter path. On a start pulse it walks a SPR_W x SPR_H sprite stored in a shared sprite ROM (one of NUM_SPRITES, selected per draw). It emits one pixel write per cycle at a runtime-chosen screen origin, with optional colour-key transparency and off-screen clipping. It then signals done, so the top-level scheduler can sequence cookie, building and upgrade icons through one VGA write port.

Parameters:
SPR_W, 50, sprite width in pixels
SPR_H, 50, sprite height in pixels
NUM_SPRITES, 3, sprites packed consecutively in ROM; base address = sel*SPR_W*SPR_H
X_W, 9, screen x coordinate width
Y_W, 9, screen y coordinate width
COLOUR_W, 4, pixel colour width
ADDR_W, 13, ROM address width; must hold NUM_SPRITES*SPR_W*SPR_H-1
SCREEN_W, 320, pixels with x >= SCREEN_W are clipped
SCREEN_H, 240, pixels with y >= SCREEN_H are clipped
ROM_LAT, 1, ROM read latency in cycles (address registered to data valid)
KEY_COLOUR, 4'hF, transparent colour when keying is enabled

Ports:
clock  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  draw request, sampled only in IDLE
sprite_sel  in  2  sprite index, latched on start
origin_x  in  X_W  top-left x, latched on start
origin_y  in  Y_W  top-left y, latched on start
key_en  in  1  transparency enable, latched on start
busy  out  1  high from start acceptance until done cycle inclusive
done  out  1  one-cycle pulse after the last pixel slot
rom_addr  out  ADDR_W  sprite ROM address
rom_data  in  COLOUR_W  ROM output, valid ROM_LAT cycles after rom_addr
writeEn  out  1  VGA pixel write strobe
x  out  X_W  pixel x
y  out  Y_W  pixel y
colour  out  COLOUR_W  pixel colour

Behaviour:
- Reset (async, any state, including mid-draw): state IDLE. busy, done, writeEn = 0. x, y, colour, rom_addr = 0. Counters and pipeline valid bits cleared. No partial writes occur after deassertion.
- States: IDLE -> DRAW on start. DRAW -> FLUSH after the address for (col=SPR_W-1,row=SPR_H-1) is issued. FLUSH -> DONE after ROM_LAT+1 cycles. DONE -> IDLE unconditionally. done=1 only in DONE.
- start accepted at edge E0 latches sel, origin_x, origin_y and key_en. If sel >= NUM_SPRITES, sel is treated as 0. start is ignored when not in IDLE.
- DRAW issues one address per cycle in raster order, col fastest: rom_addr = base + row*SPR_W + col. The first address is valid in the cycle after E0. Exactly SPR_W*SPR_H address cycles.
- A ROM_LAT-deep shift pipeline carries valid, col and row alongside each read.
- Output stage (registered): when a pipeline entry arrives with rom_data valid, then x = origin_x+col and y = origin_y+row, computed 1 bit wider than X_W/Y_W. colour = rom_data.
  - writeEn=1 only if: x < SCREEN_W, y < SCREEN_H, no overflow, and !(key_en && rom_data==KEY_COLOUR).
  - Otherwise writeEn=0, while x, y and colour still update.
- Latency: the write for pixel (0,0) appears ROM_LAT+1 cycles after the first address cycle. Total start-to-done = SPR_W*SPR_H + ROM_LAT + 2 cycles.
- writeEn is 0 in IDLE, DONE and the FLUSH tail cycles with no valid data. x, y and colour hold their last value.
- start asserted in the DONE cycle is ignored. Back-to-back draws need start in IDLE, i.e. one idle cycle minimum.

Decomposition:
- Shared package: state enum (IDLE, DRAW, FLUSH, DONE), KEY_COLOUR default, and a clog2-based width helper for ADDR_W sizing checks.
- One sub-module, sprite_addr_gen: col/row counters, base-address multiply, last-pixel flag. FSM, pipeline and output stage stay in sprite_blitter.

Test Plan:
- SPR_W=4, SPR_H=3, ROM_LAT=1, sel=0, origin (200,150), key_en=0. Expect 12 writes in raster order, (200,150)..(203,152), colour = ROM[0..11]. done pulses exactly 15 cycles after start acceptance; busy high for 15 cycles.
- sel=2, same geometry. Expect rom_addr sequence 24..35, with colours matching ROM[24..35].
- key_en=1, ROM[5]=4'hF. Expect 11 writeEn pulses, none at (201,151). Repeat with key_en=0: 12 pulses.
- origin (318,238). Expect writes only for x in {318,319} and y in {238,239}, i.e. 4 pulses. No wrap to x=0. done timing unchanged.
- resetn low at the 6th write, released, then start again. Expect all outputs 0 during reset. The new draw begins cleanly from (0,0) of the sprite. No stale write from the aborted pipeline.
- start held high throughout, plus pulses while busy. Expect exactly one draw per IDLE acceptance. Mid-draw pulses have no effect; the sel/origin change mid-draw is ignored.
